// File: rtl/halton_pkg.sv
// rtl/halton_pkg.sv - shared types and elaboration helpers for the Halton generator
package halton_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Integer power; used to derive the per-dimension scale factor
    function automatic longint unsigned ipow(input int unsigned base, input int unsigned exp);
        longint unsigned result;
        result = 64'd1;
        for (int unsigned i = 0; i < exp; i++) begin
            result = result * longint'(base);
        end
        return result;
    endfunction

    function automatic int unsigned imax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // True when the factor is representable in a width-bit unsigned value
    function automatic bit factor_fits(input longint unsigned f, input int unsigned width);
        if (width >= 64) begin
            return 1'b1;
        end
        return f < (64'd1 << width);
    endfunction

    // A dimension is legal when its base is >=2, it keeps at least one digit
    // and its factor fits the datapath
    function automatic bit dim_params_ok(input int unsigned width, input int unsigned base,
                                         input int unsigned scale);
        return (base >= 2) && (scale >= 1) && factor_fits(ipow(base, scale), width);
    endfunction

endpackage

// File: rtl/vdc_digit_engine.sv
// rtl/vdc_digit_engine.sv - one-digit-per-cycle Van der Corput radical-inverse engine
module vdc_digit_engine
    import halton_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BASE  = 2,
    parameter int unsigned SCALE = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step_en,
    input  logic [WIDTH-1:0] k_in,
    output logic [WIDTH-1:0] acc
);

    localparam int unsigned      SW     = $clog2(SCALE + 1);
    localparam logic [WIDTH-1:0] B      = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] FACTOR = WIDTH'(ipow(BASE, SCALE));

    logic [WIDTH-1:0] k_q;
    logic [WIDTH-1:0] fac_q;
    logic [WIDTH-1:0] acc_q;
    logic [SW-1:0]    step_q;

    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] fac_div;
    logic [WIDTH-1:0] k_div;
    logic             can_step;

    // Constant-divisor digit extraction for the current step
    always_comb begin
        digit    = k_q % B;
        fac_div  = fac_q / B;
        k_div    = k_q / B;
        can_step = step_en && (step_q < SW'(SCALE)) && (k_q != '0);
    end

    // Load a fresh index, then peel off one low-order digit per enabled cycle;
    // digits past SCALE are dropped and a zero remainder freezes the engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            fac_q  <= '0;
            acc_q  <= '0;
            step_q <= '0;
        end else if (load) begin
            k_q    <= k_in;
            fac_q  <= FACTOR;
            acc_q  <= '0;
            step_q <= '0;
        end else if (can_step) begin
            k_q    <= k_div;
            fac_q  <= fac_div;
            acc_q  <= acc_q + digit * fac_div;
            step_q <= step_q + SW'(1);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/halton_gen_param.sv
// rtl/halton_gen_param.sv - 2-D Halton point generator with request/result handshakes
module halton_gen_param
    import halton_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned BASE_0  = 2,
    parameter int unsigned SCALE_0 = 11,
    parameter int unsigned BASE_1  = 3,
    parameter int unsigned SCALE_1 = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop_valid,
    output logic             pop_ready,
    input  logic             reseed_enable,
    input  logic [WIDTH-1:0] seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] halton_out_0,
    output logic [WIDTH-1:0] halton_out_1
);

    localparam int unsigned L  = imax(SCALE_0, SCALE_1);
    localparam int unsigned CW = $clog2(L + 1);

    // Reject illegal bases or factors that would overflow the datapath
    if (!dim_params_ok(WIDTH, BASE_0, SCALE_0)) begin : g_bad_dim0
        $error("halton_gen_param: BASE_0/SCALE_0 illegal for WIDTH");
    end
    if (!dim_params_ok(WIDTH, BASE_1, SCALE_1)) begin : g_bad_dim1
        $error("halton_gen_param: BASE_1/SCALE_1 illegal for WIDTH");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;
    logic [CW-1:0]    calc_cnt;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] out0_q;
    logic [WIDTH-1:0] out1_q;

    logic             accept;
    logic             calc_done;
    logic             eng_step;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] acc0;
    logic [WIDTH-1:0] acc1;

    assign k_next = count + WIDTH'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; reseed overrides everything
    always_comb begin
        state_nxt = state;
        if (reseed_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)    state_nxt = CALC;
                CALC:    if (calc_done) state_nxt = OUT;
                OUT:     if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake and engine control decoded from state; ready_q keeps
    // pop_ready low while reset is held
    always_comb begin
        pop_ready = ready_q && (state == IDLE) && !reseed_enable;
        accept    = pop_valid && pop_ready;
        calc_done = (state == CALC) && (calc_cnt == CW'(L));
        eng_step  = (state == CALC) && !calc_done && !reseed_enable;
    end

    // Counter, step timer and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            count    <= '0;
            calc_cnt <= '0;
            valid_q  <= 1'b0;
            out0_q   <= '0;
            out1_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            if (reseed_enable) begin
                count    <= seed;
                calc_cnt <= '0;
                valid_q  <= 1'b0;
                out0_q   <= '0;
                out1_q   <= '0;
            end else begin
                if (accept) begin
                    count    <= k_next;
                    calc_cnt <= '0;
                end else if (eng_step) begin
                    calc_cnt <= calc_cnt + CW'(1);
                end
                if (calc_done) begin
                    out0_q  <= acc0;
                    out1_q  <= acc1;
                    valid_q <= 1'b1;
                end else if ((state == OUT) && out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    vdc_digit_engine #(
        .WIDTH (WIDTH),
        .BASE  (BASE_0),
        .SCALE (SCALE_0)
    ) u_eng0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step_en (eng_step),
        .k_in    (k_next),
        .acc     (acc0)
    );

    vdc_digit_engine #(
        .WIDTH (WIDTH),
        .BASE  (BASE_1),
        .SCALE (SCALE_1)
    ) u_eng1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step_en (eng_step),
        .k_in    (k_next),
        .acc     (acc1)
    );

    assign out_valid    = valid_q;
    assign halton_out_0 = out0_q;
    assign halton_out_1 = out1_q;

endmodule
